// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arbiter_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    // Wide enough for the largest legal MAX_WAIT (255).
    localparam int WAIT_W = 8;

    typedef struct packed {
        logic        we;
        logic        bh;
        logic        bhext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        req_id_t     owner;
    } access_t;

    function automatic logic [1:0] id_onehot(input req_id_t id);
        return (id == REQ_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester and memory-side bus of the data-memory arbiter
interface dm_arbiter_if;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0]       bh;
    logic [1:0]       bhext;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0][31:0] pc;
    logic [1:0]       gnt;
    logic [31:0]      rdata;
    logic [1:0]       rvalid;
    logic [31:0]      mem_a;
    logic [31:0]      mem_wd;
    logic             mem_we;
    logic             mem_bh;
    logic             mem_bhext;
    logic [31:0]      mem_pc;
    logic [31:0]      mem_rd;
    logic             busy;

    modport slave (
        input  req, we, bh, bhext, addr, wdata, pc, mem_rd,
        output gnt, rdata, rvalid, mem_a, mem_wd, mem_we, mem_bh, mem_bhext, mem_pc, busy
    );

    modport master (
        output req, we, bh, bhext, addr, wdata, pc, mem_rd,
        input  gnt, rdata, rvalid, mem_a, mem_wd, mem_we, mem_bh, mem_bhext, mem_pc, busy
    );
endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// rtl/dm_arbiter_rr_pick2.sv - two-way grant pick with starvation override
module rr_pick2
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic [1:0] sat,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    logic [1:0] other;

    assign other = (last_owner == REQ_DMA) ? 2'b01 : 2'b10;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                // A starved requester beats the tie-break policy.
                if (sat == 2'b11)   gnt = other;
                else if (sat[0])    gnt = 2'b01;
                else if (sat[1])    gnt = 2'b10;
                else if (fixed_prio) gnt = 2'b01;
                else                gnt = other;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester accept/access sequencer for the data memory
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b1,
    parameter int MAX_WAIT   = 8
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    logic [1:0]             pick;
    logic [1:0]             gnt;
    logic [1:0]             sat;
    logic [1:0][WAIT_W-1:0] wait_cnt;
    req_id_t                last_owner;
    access_t                acc;
    access_t                acc_next;
    logic                   stage_valid;
    logic                   sel;
    logic [1:0]             rvalid_q;
    logic [31:0]            rdata_q;

    always_comb begin
        sat = 2'b00;
        for (int i = 0; i < 2; i++) sat[i] = (wait_cnt[i] >= MAX_W);
    end

    rr_pick2 u_pick (
        .req        (bus.req),
        .last_owner (last_owner),
        .sat        (sat),
        .fixed_prio (FIXED_PRIO),
        .gnt        (pick)
    );

    // A grant in a reset cycle would be discarded anyway, so never show it.
    assign gnt = reset ? 2'b00 : pick;

    always_comb begin
        sel            = gnt[1];
        acc_next       = acc;
        acc_next.we    = bus.we[sel];
        acc_next.bh    = bus.bh[sel];
        acc_next.bhext = bus.bhext[sel];
        acc_next.addr  = bus.addr[sel];
        acc_next.wdata = bus.wdata[sel];
        acc_next.pc    = bus.pc[sel];
        acc_next.owner = sel ? REQ_DMA : REQ_CPU;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
            acc         <= '0;
            rvalid_q    <= 2'b00;
            rdata_q     <= 32'h0;
            last_owner  <= REQ_DMA;
            wait_cnt    <= '0;
        end else begin
            stage_valid <= |gnt;
            if (|gnt) acc <= acc_next;

            if (gnt[0])      last_owner <= REQ_CPU;
            else if (gnt[1]) last_owner <= REQ_DMA;

            rvalid_q <= (stage_valid && !acc.we) ? id_onehot(acc.owner) : 2'b00;
            if (stage_valid && !acc.we) rdata_q <= bus.mem_rd;

            for (int i = 0; i < 2; i++) begin
                if (!bus.req[i] || gnt[i]) wait_cnt[i] <= '0;
                else if (!sat[i])          wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    // Address/data lines hold their last value when idle; only the strobe drops.
    assign bus.gnt       = gnt;
    assign bus.busy      = stage_valid & ~reset;
    assign bus.mem_we    = stage_valid & acc.we & ~reset;
    assign bus.mem_a     = acc.addr;
    assign bus.mem_wd    = acc.wdata;
    assign bus.mem_bh    = acc.bh;
    assign bus.mem_bhext = acc.bhext;
    assign bus.mem_pc    = acc.pc;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter with directed vectors
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, mem_clr;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    dm_arbiter_if ifa ();
    dm_arbiter_if ifb ();

    dm_arbiter #(.FIXED_PRIO(1'b1), .MAX_WAIT(3)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    dm_arbiter #(.FIXED_PRIO(1'b0), .MAX_WAIT(8)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-capable memories with combinational read, one per DUT.
    logic [7:0] mema [256];
    logic [7:0] memb [256];

    function automatic logic [31:0] fmt(input logic [31:0] word, input logic [7:0] b,
                                        input logic bh, input logic bhext);
        if (!bh) return word;
        return bhext ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) begin
                mema[k] <= 8'h0;
                memb[k] <= 8'h0;
            end
        end else begin
            if (ifa.mem_we) begin
                if (ifa.mem_bh) mema[ifa.mem_a[7:0]] <= ifa.mem_wd[7:0];
                else for (int k = 0; k < 4; k++) mema[{ifa.mem_a[7:2], 2'(k)}] <= ifa.mem_wd[8*k +: 8];
            end
            if (ifb.mem_we) begin
                if (ifb.mem_bh) memb[ifb.mem_a[7:0]] <= ifb.mem_wd[7:0];
                else for (int k = 0; k < 4; k++) memb[{ifb.mem_a[7:2], 2'(k)}] <= ifb.mem_wd[8*k +: 8];
            end
        end
    end

    assign ifa.mem_rd = fmt({mema[{ifa.mem_a[7:2], 2'd3}], mema[{ifa.mem_a[7:2], 2'd2}],
                             mema[{ifa.mem_a[7:2], 2'd1}], mema[{ifa.mem_a[7:2], 2'd0}]},
                            mema[ifa.mem_a[7:0]], ifa.mem_bh, ifa.mem_bhext);
    assign ifb.mem_rd = fmt({memb[{ifb.mem_a[7:2], 2'd3}], memb[{ifb.mem_a[7:2], 2'd2}],
                             memb[{ifb.mem_a[7:2], 2'd1}], memb[{ifb.mem_a[7:2], 2'd0}]},
                            memb[ifb.mem_a[7:0]], ifb.mem_bh, ifb.mem_bhext);

    typedef struct {
        int          cyc;
        logic [1:0]  rv;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Monitor: every read response must match the oldest expected one, in its cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (ifa.rvalid !== 2'b00) begin
            if (qa.size() == 0) chk("a_unexpected_rvalid", 32'(ifa.rvalid), 32'h0);
            else begin
                e = qa.pop_front();
                chk("a_rvalid_cycle", 32'(cyc), 32'(e.cyc));
                chk("a_rvalid", 32'(ifa.rvalid), 32'(e.rv));
                chk("a_rdata", ifa.rdata, e.data);
            end
        end
        if (ifb.rvalid !== 2'b00) begin
            if (qb.size() == 0) chk("b_unexpected_rvalid", 32'(ifb.rvalid), 32'h0);
            else begin
                e = qb.pop_front();
                chk("b_rvalid_cycle", 32'(cyc), 32'(e.cyc));
                chk("b_rvalid", 32'(ifb.rvalid), 32'(e.rv));
                chk("b_rdata", ifb.rdata, e.data);
            end
        end
    end

    task automatic clr_a();
        ifa.req = '0; ifa.we = '0; ifa.bh = '0; ifa.bhext = '0;
        ifa.addr = '0; ifa.wdata = '0; ifa.pc = '0;
    endtask

    task automatic clr_b();
        ifb.req = '0; ifb.we = '0; ifb.bh = '0; ifb.bhext = '0;
        ifb.addr = '0; ifb.wdata = '0; ifb.pc = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [1:0] tie_gnt  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    logic       tie_busy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] stv_gnt  [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; mem_clr = 1'b1;
        clr_a(); clr_b();
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; mem_clr = 1'b0;
        mid();
        chk("rst_gnt",    32'(ifa.gnt), 32'h0);
        chk("rst_rvalid", 32'(ifa.rvalid), 32'h0);
        chk("rst_rdata",  ifa.rdata, 32'h0);
        chk("rst_busy",   32'(ifa.busy), 32'h0);
        chk("rst_mem_we", 32'(ifa.mem_we), 32'h0);
        chk("rst_mem_a",  ifa.mem_a, 32'h0);
        chk("rst_mem_pc", ifa.mem_pc, 32'h0);

        // Tie on the round-robin instance.
        for (int i = 0; i < 6; i++) begin
            next();
            if (i < 4) begin
                ifb.req = 2'b11; ifb.we = 2'b11;
                ifb.addr[0] = 32'h80 + 32'(8 * i); ifb.addr[1] = 32'hC0 + 32'(8 * i);
                ifb.wdata[0] = 32'(i); ifb.wdata[1] = 32'(i + 16);
            end else clr_b();
            mid();
            chk("tie_gnt",  32'(ifb.gnt), 32'(tie_gnt[i]));
            chk("tie_busy", 32'(ifb.busy), 32'(tie_busy[i]));
        end

        // Requester 0 word store then load.
        next();
        ifa.req = 2'b01; ifa.we = 2'b01; ifa.addr[0] = 32'h10;
        ifa.wdata[0] = 32'hDEADBEEF; ifa.pc[0] = 32'h100;
        mid();
        chk("st_gnt", 32'(ifa.gnt), 32'h1);
        chk("st_mem_we_accept", 32'(ifa.mem_we), 32'h0);
        next();
        ifa.we = 2'b00; ifa.pc[0] = 32'h104;
        qa.push_back('{cyc: cyc + 2, rv: 2'b01, data: 32'hDEADBEEF});
        mid();
        chk("ld_gnt", 32'(ifa.gnt), 32'h1);
        chk("st_mem_we", 32'(ifa.mem_we), 32'h1);
        chk("st_mem_a", ifa.mem_a, 32'h10);
        chk("st_mem_wd", ifa.mem_wd, 32'hDEADBEEF);
        chk("st_mem_pc", ifa.mem_pc, 32'h100);
        next(); clr_a(); mid();
        chk("ld_mem_we", 32'(ifa.mem_we), 32'h0);
        chk("ld_busy", 32'(ifa.busy), 32'h1);
        chk("idle_gnt", 32'(ifa.gnt), 32'h0);
        next(); mid();
        chk("idle_busy", 32'(ifa.busy), 32'h0);
        next();

        // Requester 1 byte store, then sign- and zero-extending byte loads.
        ifa.req = 2'b10; ifa.we = 2'b10; ifa.bh = 2'b10;
        ifa.addr[1] = 32'h23; ifa.wdata[1] = 32'h80;
        mid();
        chk("bst_gnt", 32'(ifa.gnt), 32'h2);
        next();
        ifa.we = 2'b00; ifa.bhext = 2'b00;
        qa.push_back('{cyc: cyc + 2, rv: 2'b10, data: 32'hFFFFFF80});
        mid();
        chk("bld_gnt", 32'(ifa.gnt), 32'h2);
        chk("bst_mem_bh", 32'(ifa.mem_bh), 32'h1);
        chk("bst_mem_we", 32'(ifa.mem_we), 32'h1);
        chk("bst_mem_a", ifa.mem_a, 32'h23);
        next();
        ifa.bhext = 2'b10;
        qa.push_back('{cyc: cyc + 2, rv: 2'b10, data: 32'h00000080});
        mid();
        chk("bld_s_mem_bh", 32'(ifa.mem_bh), 32'h1);
        chk("bld_s_mem_we", 32'(ifa.mem_we), 32'h0);
        next(); clr_a(); mid();
        chk("bld_z_mem_bh", 32'(ifa.mem_bh), 32'h1);
        chk("bld_z_mem_bhext", 32'(ifa.mem_bhext), 32'h1);
        next(); mid();
        chk("idle_mem_we", 32'(ifa.mem_we), 32'h0);
        chk("idle_mem_a_hold", ifa.mem_a, 32'h23);
        next();

        // Starvation: fixed priority, MAX_WAIT=3.
        for (int i = 0; i < 5; i++) begin
            ifa.req = 2'b11; ifa.we = 2'b11;
            ifa.addr[0] = 32'h60; ifa.addr[1] = 32'h64;
            ifa.wdata[0] = 32'hA0 + 32'(i); ifa.wdata[1] = 32'hB0 + 32'(i);
            mid();
            chk("starve_gnt", 32'(ifa.gnt), 32'(stv_gnt[i]));
            next();
        end
        clr_a(); mid();
        chk("starve_end_gnt", 32'(ifa.gnt), 32'h0);
        next();

        // Requester 1 withdraws before being granted.
        ifa.req = 2'b11; ifa.we = 2'b11;
        ifa.addr[0] = 32'h70; ifa.wdata[0] = 32'h11;
        ifa.addr[1] = 32'h40; ifa.wdata[1] = 32'h55;
        mid();
        chk("wd_gnt_c1", 32'(ifa.gnt), 32'h1);
        chk("wd_cnt_c1", 32'(dut_a.wait_cnt[1]), 32'h0);
        next(); mid();
        chk("wd_gnt_c2", 32'(ifa.gnt), 32'h1);
        chk("wd_cnt_c2", 32'(dut_a.wait_cnt[1]), 32'h1);
        next();
        ifa.req = 2'b01;
        mid();
        chk("wd_gnt_c3", 32'(ifa.gnt), 32'h1);
        chk("wd_cnt_c3", 32'(dut_a.wait_cnt[1]), 32'h2);
        next(); clr_a(); mid();
        chk("wd_cnt_cleared", 32'(dut_a.wait_cnt[1]), 32'h0);
        chk("wd_gnt_c4", 32'(ifa.gnt), 32'h0);
        next(); mid();
        chk("wd_no_access", 32'(mema[8'h40]), 32'h0);
        next();

        // Reset arrives while a store is in ACCESS.
        ifa.req = 2'b01; ifa.we = 2'b01;
        ifa.addr[0] = 32'h50; ifa.wdata[0] = 32'h12345678;
        mid();
        chk("rm_gnt_n", 32'(ifa.gnt), 32'h1);
        next();
        rst_a = 1'b1; ifa.we = 2'b00;
        mid();
        chk("rm_mem_we_n1", 32'(ifa.mem_we), 32'h0);
        chk("rm_gnt_n1", 32'(ifa.gnt), 32'h0);
        next();
        rst_a = 1'b0; clr_a();
        mid();
        chk("rm_rvalid_n2", 32'(ifa.rvalid), 32'h0);
        chk("rm_busy_n2", 32'(ifa.busy), 32'h0);
        chk("rm_gnt_n2", 32'(ifa.gnt), 32'h0);
        chk("rm_rdata_n2", ifa.rdata, 32'h0);
        next(); mid();
        chk("rm_no_write", {mema[8'h53], mema[8'h52], mema[8'h51], mema[8'h50]}, 32'h0);

        repeat (4) next();
        chk("a_pending_responses", 32'(qa.size()), 32'h0);
        chk("b_pending_responses", 32'(qb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port byte-capable data memory.
- Requester 0 is the CPU M stage; requester 1 is the DMA/debug loader.
- Accepts one request per cycle, registers it, and drives the memory for exactly one cycle. Registers the read result and returns it with a valid strobe to the owner.
- Sits between the pipeline/loader and the data memory; the pipeline stalls on c_req && !gnt[0].

Parameters:
- FIXED_PRIO, 1, 1 = requester 0 wins ties (subject to MAX_WAIT); 0 = round-robin on ties.
- MAX_WAIT, 8, wait cycles after which a waiting requester is force-granted. Range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  2  per-requester request. Held until granted.
- we  in  2  per-requester write enable
- bh  in  2  per-requester byte-access select
- bhext  in  2  per-requester byte load extend (0 sign, 1 zero)
- addr  in  64  {addr1, addr0}, byte addresses
- wdata  in  64  {wdata1, wdata0}
- pc  in  64  {pc1, pc0}, forwarded for the write trace
- gnt  out  2  one-hot accept pulse. Request fields are sampled on this cycle.
- rdata  out  32  registered read data, shared
- rvalid  out  2  one-hot read-data valid. Loads only.
- mem_a  out  32  memory address
- mem_wd  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_bh  out  1  memory byte select
- mem_bhext  out  1  memory byte extend
- mem_pc  out  32  memory trace pc
- mem_rd  in  32  memory combinational read data
- busy  out  1  an access is in the memory stage this cycle

Behaviour:
- Reset (synchronous, highest priority):
  - gnt=0, rvalid=0, rdata=0, busy=0, mem_we=0.
  - mem_a, mem_wd, mem_pc = 0; mem_bh=0, mem_bhext=0.
  - last_owner=1, so requester 0 wins the first tie. Both wait counters = 0.
  - A request accepted in the cycle reset asserts is discarded; no memory write occurs.
- Pipeline: two stages, ACCEPT and ACCESS.
  - Cycle N (ACCEPT): combinational arbitration over req. gnt pulses for the winner. On the clock edge its we/bh/bhext/addr/wdata/pc are latched into the access register with owner id; stage valid is set.
  - Cycle N+1 (ACCESS): busy=1 and mem_* are driven from the access register. mem_we equals the latched we; it is never high when the stage is invalid. For a load, rdata <= mem_rd on the edge.
  - Cycle N+2: rvalid[owner]=1 for one cycle; rdata holds until the next load completes.
  - Stores produce no rvalid.
  - Throughput is one access per cycle; ACCEPT of the next request overlaps ACCESS of the previous one.
- Arbitration, evaluated in this order:
  1. Only one req high: grant it.
  2. Both high and a wait counter has reached MAX_WAIT: grant that requester. If both have reached it, grant the one not equal to last_owner.
  3. Both high, FIXED_PRIO=1: grant 0.
  4. Both high, FIXED_PRIO=0: grant the requester != last_owner.
  5. last_owner is updated on every grant.
- Wait counters:
  - Per requester: +1 each cycle req is high and not granted; cleared on grant or when req is low.
  - Saturate at MAX_WAIT.
  - With FIXED_PRIO=1 and continuous requester-0 traffic, requester 1 is granted on the cycle its counter reaches MAX_WAIT.
- Memory-side idle values: mem_* keep their last values when idle, except mem_we, which is 0.
- Hazard: a requester-0 load in ACCEPT while a requester-1 store to the same word is in ACCESS sees the post-store data. The memory writes at the end of ACCESS, and the load reads in its own ACCESS cycle. No forwarding is needed.
- Protocol violation: req dropped before gnt is legal. The counter clears and no access is made.
- gnt is never high for a requester whose req is low.

Decomposition:
- Shared package:
  - requester ids REQ_CPU=0 and REQ_DMA=1
  - access record typedef {we, bh, bhext, addr, wdata, pc, owner}
  - MAX_WAIT width constant
- One sub-module, rr_pick2: two-way pick logic with starvation override. Inputs are req, last_owner, sat[1:0] and FIXED_PRIO; output is a one-hot grant. The remainder (access register, counters, response register) stays in dm_arbiter.

Test Plan:
- Requester-0 store then load:
  - Cycle 1: req=01, we=01, addr0=0x10, wdata0=0xDEADBEEF.
  - Cycle 2: load 0x10.
  - Expected: gnt0 in cycles 1 and 2; mem_we=1 in cycle 2 only; rvalid=01 with rdata=0xDEADBEEF in cycle 4.
- Byte path:
  - Requester 1 issues a byte store, bh=1, addr1=0x23, wdata1=0x80.
  - Requester 1 then issues a byte load, bh=1, bhext=0, addr1=0x23.
  - Expected: mem_bh=1 in both ACCESS cycles; rvalid=10, rdata=0xFFFFFF80.
  - Repeat with bhext=1: rdata=0x00000080.
- Tie, FIXED_PRIO=0: both req held for 4 cycles.
  - Expected: gnt sequence 01, 10, 01, 10; busy high in cycles 2–5.
- Starvation, FIXED_PRIO=1, MAX_WAIT=3: req=11 held continuously.
  - Expected: gnt=01 in cycles 1–3; gnt=10 in cycle 4; gnt=01 in cycle 5.
- Reset mid-operation: a store is accepted in cycle N and reset is asserted in cycle N+1.
  - Expected: mem_we=0 in cycle N+1; rvalid=0, busy=0, gnt=0 in cycle N+2.
- Request withdrawn: req1 high for 2 cycles while requester 0 holds priority, then low.
  - Expected: gnt1 never asserted and no memory access for requester 1. The wait counter reads 0 one cycle after req1 falls.
